shift_register_universal: RTL and testbench
===========================================

# shift_register_universal

Parametrised universal shift register, the successor to the fixed 8-bit serial-in/parallel-out register. It supports hold, shift right, shift left and parallel load on a WIDTH-bit register, with serial outputs at both ends. A drain counter tracks how many shifts have occurred since the last load. It serves the serializer/deserializer paths and any datapath that needs a configurable-width shifter with load.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0, value of q after reset, WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the shift counter.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- ser_in_r  input  1  serial input entering at bit WIDTH-1 on a right shift.
- ser_in_l  input  1  serial input entering at bit 0 on a left shift.
- d_in  input  WIDTH  parallel load data.
- rot  input  1  rotate select; only present with SHIFT_REG_ROTATE_EN.
- q  output  WIDTH  register contents.
- ser_out_r  output  1  q[0], the bit leaving on a right shift.
- ser_out_l  output  1  q[WIDTH-1], the bit leaving on a left shift.
- shift_cnt  output  CNT_W  shifts since the last load, saturating at WIDTH.
- drained  output  1  high when shift_cnt == WIDTH, meaning all loaded bits have been shifted out.

## Operation
- Mode 00: q, shift_cnt and drained hold.
- Mode 01: q <= {ser_in_r, q[WIDTH-1:1]}; shift_cnt increments.
- Mode 10: q <= {q[WIDTH-2:0], ser_in_l}; shift_cnt increments.
- Mode 11: q <= d_in; shift_cnt <= 0; drained <= 0.
- shift_cnt saturates at WIDTH. Shifts while drained still move q, but the counter stays at WIDTH.
- drained is registered and equals (next shift_cnt == WIDTH).
- Direction changes mid-word (01 then 10) still count as shifts. The counter counts shift operations, not net displacement.
- The mode is sampled every cycle with no handshake. The caller holds mode for the number of cycles it wants.

## Timing
- Reset (asynchronous assertion, synchronous-safe release): q = RESET_VAL, shift_cnt = WIDTH, drained = 1. The post-reset state counts as "nothing loaded".
- Reset asserted mid-word discards the partial word immediately, without waiting for a clock edge.
- Latency: q, shift_cnt and drained reflect the mode one clk edge after it is sampled.
- ser_out_r and ser_out_l are combinational from q and carry no extra delay.
- The first post-reset edge with rst_n high performs the sampled mode.
- Load and shift are mutually exclusive by encoding, so there is no simultaneous-event priority to resolve.

## Configuration
- Macro: SHIFT_REG_ROTATE_EN.
- Defined: the rot port exists. On a shift with rot=1:
  - right shift: q <= {q[0], q[WIDTH-1:1]}.
  - left shift: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - ser_in_r and ser_in_l are ignored.
  - shift_cnt and drained behave exactly as for a non-rotating shift.
  - rot has no effect in modes 00 and 11.
- Undefined: the rot port is absent and shifts always take the serial inputs.

## Structure
- Shared header package shift_reg_defs holds:
  - mode constants SR_HOLD=2'b00, SR_SHR=2'b01, SR_SHL=2'b10, SR_LOAD=2'b11;
  - the include guard.
- One natural sub-module, shift_reg_cell. It is a single bit holding a 4:1 next-state mux plus a flop with async active-low reset and a per-bit reset value. It is instantiated WIDTH times in a generate loop with neighbour wiring.
- The counter and drained logic live in the top level.

## Test plan
All scenarios use WIDTH=8.
- Reset check: with RESET_VAL=8'hA5, assert rst_n=0 between edges -> q=8'hA5, shift_cnt=8, drained=1 without any clock edge.
- Load then right shifts: load 8'h81, then 8 right shifts with ser_in_r=0 -> ser_out_r sequence 1,0,0,0,0,0,0,1; q=8'h00; drained rises on the 8th edge; a 9th shift keeps shift_cnt=8.
- Left fill: from reset with RESET_VAL=0, 4 left shifts with ser_in_l=1 -> q=8'h0F; shift_cnt stays 8 because no load occurred.
- Mid-word hold and reload: load 8'h3C, shift right twice, hold 3 cycles -> q=8'h0F, shift_cnt=2; then load 8'hFF -> shift_cnt=0, drained=0.
- Reset mid-word: load 8'hC3, shift left 3 times, pulse rst_n low -> q=RESET_VAL, shift_cnt=8, drained=1 immediately.
- Rotate (SHIFT_REG_ROTATE_EN only): load 8'h01, rot=1, 8 left shifts -> q=8'h01 again; drained=1; ser_in_l toggling has no effect.

Source files
------------

// File: rtl/shift_reg_defs.sv
// Mode encodings shared by the universal shift register and its bit cell.
`ifndef SHIFT_REG_DEFS_SV
`define SHIFT_REG_DEFS_SV
package shift_reg_defs;
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SHR  = 2'b01;
    localparam logic [1:0] SR_SHL  = 2'b10;
    localparam logic [1:0] SR_LOAD = 2'b11;
endpackage
`endif

// File: rtl/shift_register_universal_cell.sv
// One register bit: 4:1 next-state mux (hold/right/left/load) and a flop with its own reset value.
module shift_reg_cell
    import shift_reg_defs::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       shr_bit,
    input  logic       shl_bit,
    input  logic       d,
    output logic       q
);
    logic q_next;

    always_comb begin
        q_next = q;
        case (mode)
            SR_HOLD: q_next = q;
            SR_SHR:  q_next = shr_bit;
            SR_SHL:  q_next = shl_bit;
            SR_LOAD: q_next = d;
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= q_next;
    end
endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register (hold / shift right / shift left / load) with a saturating drain counter.
// Optional feature: SHIFT_REG_ROTATE_EN adds the rot port for end-around rotation.
module shift_register_universal
    import shift_reg_defs::*;
#(
    parameter int             WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int             CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] d_in,
`ifdef SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             drained
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    logic             ser_r_eff;
    logic             ser_l_eff;
    logic [WIDTH-1:0] shr_src;
    logic [WIDTH-1:0] shl_src;
    logic [CNT_W-1:0] cnt_next;

`ifdef SHIFT_REG_ROTATE_EN
    assign ser_r_eff = rot ? q[0]       : ser_in_r;
    assign ser_l_eff = rot ? q[WIDTH-1] : ser_in_l;
`else
    assign ser_r_eff = ser_in_r;
    assign ser_l_eff = ser_in_l;
`endif

    // Per-bit neighbour sources for each shift direction.
    assign shr_src = {ser_r_eff, q[WIDTH-1:1]};
    assign shl_src = {q[WIDTH-2:0], ser_l_eff};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shift_reg_cell #(.RST_VAL(RESET_VAL[i])) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .mode    (mode),
            .shr_bit (shr_src[i]),
            .shl_bit (shl_src[i]),
            .d       (d_in[i]),
            .q       (q[i])
        );
    end

    assign ser_out_r = q[0];
    assign ser_out_l = q[WIDTH-1];

    // Counts shift operations, not net displacement; saturates at WIDTH.
    always_comb begin
        cnt_next = shift_cnt;
        case (mode)
            SR_HOLD:        cnt_next = shift_cnt;
            SR_SHR, SR_SHL: cnt_next = (shift_cnt >= FULL) ? FULL : shift_cnt + 1'b1;
            SR_LOAD:        cnt_next = '0;
            default:        cnt_next = shift_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_cnt <= FULL;
            drained   <= 1'b1;
        end else begin
            shift_cnt <= cnt_next;
            drained   <= (cnt_next == FULL);
        end
    end
endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal (WIDTH=8), two instances with RESET_VAL A5 and 00.
module tb_shift_register_universal;
    localparam int W = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic          ser_in_r = 1'b0;
    logic          ser_in_l = 1'b0;
    logic [W-1:0]  d_in = '0;
    logic          rot = 1'b0;

    logic [W-1:0]  qa, qz;
    logic          sora, sola, sorz, solz;
    logic [CW-1:0] cnta, cntz;
    logic          dra, drz;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_register_universal #(.WIDTH(W), .RESET_VAL(8'hA5)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
        .d_in(d_in),
`ifdef SHIFT_REG_ROTATE_EN
        .rot(rot),
`endif
        .q(qa), .ser_out_r(sora), .ser_out_l(sola), .shift_cnt(cnta), .drained(dra)
    );

    shift_register_universal #(.WIDTH(W), .RESET_VAL(8'h00)) dut_z (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
        .d_in(d_in),
`ifdef SHIFT_REG_ROTATE_EN
        .rot(rot),
`endif
        .q(qz), .ser_out_r(sorz), .ser_out_l(solz), .shift_cnt(cntz), .drained(drz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (qa !== 8'hA5) begin errors++; $display("FAIL reset_q_a got=%h exp=a5", qa); end
        checks++; if (qz !== 8'h00) begin errors++; $display("FAIL reset_q_z got=%h exp=00", qz); end
        checks++; if (cnta !== CW'(8)) begin errors++; $display("FAIL reset_cnt got=%0d exp=8", cnta); end
        checks++; if (dra !== 1'b1) begin errors++; $display("FAIL reset_drained got=%b exp=1", dra); end
        checks++; if (sora !== 1'b1 || sola !== 1'b1) begin errors++; $display("FAIL reset_serout got=%b%b exp=11", sola, sora); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_load_shr();
        logic [7:0] exp_bits;
        exp_bits = 8'b1000_0001;
        mode = 2'b11; d_in = 8'h81;
        step();
        checks++; if (qa !== 8'h81) begin errors++; $display("FAIL load_q got=%h exp=81", qa); end
        checks++; if (cnta !== CW'(0) || dra !== 1'b0) begin errors++; $display("FAIL load_cnt got=%0d/%b exp=0/0", cnta, dra); end
        checks++; if (sola !== 1'b1) begin errors++; $display("FAIL load_serout_l got=%b exp=1", sola); end
        mode = 2'b01; ser_in_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (sora !== exp_bits[i]) begin errors++; $display("FAIL shr_serout[%0d] got=%b exp=%b", i, sora, exp_bits[i]); end
            step();
            checks++; if (cnta !== CW'(i + 1)) begin errors++; $display("FAIL shr_cnt[%0d] got=%0d exp=%0d", i, cnta, i + 1); end
            checks++; if (dra !== (i == 7)) begin errors++; $display("FAIL shr_drained[%0d] got=%b exp=%b", i, dra, i == 7); end
        end
        checks++; if (qa !== 8'h00) begin errors++; $display("FAIL shr_q_final got=%h exp=00", qa); end
        ser_in_r = 1'b1;
        step();
        checks++; if (cnta !== CW'(8) || dra !== 1'b1) begin errors++; $display("FAIL shr_saturate got=%0d/%b exp=8/1", cnta, dra); end
        checks++; if (qa !== 8'h80) begin errors++; $display("FAIL shr_drained_moves got=%h exp=80", qa); end
        mode = 2'b00; ser_in_r = 1'b0;
    endtask

    task automatic test_left_fill();
        pulse_reset();
        mode = 2'b10; ser_in_l = 1'b1;
        repeat (4) step();
        checks++; if (qz !== 8'h0F) begin errors++; $display("FAIL lfill_q_z got=%h exp=0f", qz); end
        checks++; if (qa !== 8'h5F) begin errors++; $display("FAIL lfill_q_a got=%h exp=5f", qa); end
        checks++; if (cntz !== CW'(8) || drz !== 1'b1) begin errors++; $display("FAIL lfill_cnt got=%0d/%b exp=8/1", cntz, drz); end
        mode = 2'b00; ser_in_l = 1'b0;
    endtask

    task automatic test_hold_reload();
        mode = 2'b11; d_in = 8'h3C;
        step();
        mode = 2'b01; ser_in_r = 1'b0;
        repeat (2) step();
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (qa !== 8'h0F || cnta !== CW'(2) || dra !== 1'b0) begin
                errors++; $display("FAIL hold[%0d] got=%h/%0d/%b exp=0f/2/0", i, qa, cnta, dra);
            end
        end
        mode = 2'b11; d_in = 8'hFF;
        step();
        checks++; if (qa !== 8'hFF || cnta !== CW'(0) || dra !== 1'b0) begin errors++; $display("FAIL reload got=%h/%0d/%b exp=ff/0/0", qa, cnta, dra); end
        mode = 2'b00;
    endtask

    task automatic test_back_to_back();
        mode = 2'b11; d_in = 8'hF0;
        step();
        mode = 2'b01; ser_in_r = 1'b1;
        step();
        checks++; if (qa !== 8'hF8) begin errors++; $display("FAIL b2b_shr got=%h exp=f8", qa); end
        mode = 2'b10; ser_in_l = 1'b0;
        step();
        checks++; if (qa !== 8'hF0 || cnta !== CW'(2)) begin errors++; $display("FAIL b2b_shl got=%h/%0d exp=f0/2", qa, cnta); end
        mode = 2'b00; ser_in_r = 1'b0;
    endtask

    task automatic test_reset_mid();
        mode = 2'b11; d_in = 8'hC3;
        step();
        mode = 2'b10; ser_in_l = 1'b0;
        repeat (3) step();
        checks++; if (qa !== 8'h18 || cnta !== CW'(3)) begin errors++; $display("FAIL mid_pre got=%h/%0d exp=18/3", qa, cnta); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (qa !== 8'hA5 || qz !== 8'h00) begin errors++; $display("FAIL mid_reset_q got=%h/%h exp=a5/00", qa, qz); end
        checks++; if (cnta !== CW'(8) || dra !== 1'b1) begin errors++; $display("FAIL mid_reset_cnt got=%0d/%b exp=8/1", cnta, dra); end
        mode = 2'b00;
        rst_n = 1'b1;
    endtask

`ifdef SHIFT_REG_ROTATE_EN
    task automatic test_rotate();
        logic [7:0] exp_q;
        mode = 2'b11; d_in = 8'h01; rot = 1'b1;
        step();
        mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            ser_in_l = i[0];
            step();
            exp_q = 8'h01 << ((i + 1) % 8);
            checks++; if (qa !== exp_q) begin errors++; $display("FAIL rotl[%0d] got=%h exp=%h", i, qa, exp_q); end
        end
        checks++; if (cnta !== CW'(8) || dra !== 1'b1) begin errors++; $display("FAIL rotl_cnt got=%0d/%b exp=8/1", cnta, dra); end
        mode = 2'b01; ser_in_r = 1'b0;
        step();
        checks++; if (qa !== 8'h80) begin errors++; $display("FAIL rotr got=%h exp=80", qa); end
        mode = 2'b00; rot = 1'b0; ser_in_l = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_shr();
        test_left_fill();
        test_hold_reload();
        test_back_to_back();
        test_reset_mid();
`ifdef SHIFT_REG_ROTATE_EN
        test_rotate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
